// File: rtl/mem.sv
// Memory-access stage: EX/MEM register, req/ack data bus sequencing with
// upstream stall, load formatting, and the MEM/WB register.
module mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [4:0]  rd_i,
  input  logic        regwe_i,
  input  logic [31:0] result_i,
  input  logic [3:0]  memop_i,
  input  logic [31:0] sdata_i,
  output logic        stall_o,
  output logic        dreq_o,
  output logic        dwe_o,
  output logic [31:0] daddr_o,
  output logic [3:0]  dbe_o,
  output logic [31:0] dwdata_o,
  input  logic [31:0] drdata_i,
  input  logic        dack_i,
  output logic [4:0]  ex_mem_rd,
  output logic        ex_mem_regwe,
  output logic [31:0] ex_mem_wbdata,
  output logic [4:0]  wb_rd,
  output logic        wb_regwe,
  output logic [31:0] wb_wbdata,
  output logic        misalign_o
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic {RUN, REQ} state_t;

  state_t      state_reg;
  logic        em_valid_reg;
  logic [4:0]  em_rd_reg;
  logic        em_regwe_reg;
  logic [31:0] em_result_reg;
  logic [3:0]  em_memop_reg;
  logic [31:0] em_sdata_reg;
  logic [4:0]  wb_rd_reg;
  logic        wb_regwe_reg;
  logic [31:0] wb_wbdata_reg;

  logic        is_load, is_store, is_mem;
  logic        size_byte, size_half, size_word;
  logic [1:0]  a;
  logic        misaligned;
  logic        mem_go;
  logic [3:0]  be_mask;
  logic [31:0] wdata_rep;
  logic [7:0]  rbyte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;

  assign a          = em_result_reg[1:0];
  assign is_load    = (em_memop_reg >= OP_LB) && (em_memop_reg <= OP_LHU);
  assign is_store   = (em_memop_reg >= OP_SB) && (em_memop_reg <= OP_SW);
  assign is_mem     = is_load || is_store;
  assign size_byte  = (em_memop_reg == OP_LB) || (em_memop_reg == OP_LBU) || (em_memop_reg == OP_SB);
  assign size_half  = (em_memop_reg == OP_LH) || (em_memop_reg == OP_LHU) || (em_memop_reg == OP_SH);
  assign size_word  = (em_memop_reg == OP_LW) || (em_memop_reg == OP_SW);
  assign misaligned = (size_half && a[0]) || (size_word && (a != 2'b00));

  // Only a valid, aligned memory op leaves RUN; everything else retires in one cycle.
  assign mem_go     = em_valid_reg && is_mem && !misaligned;
  assign misalign_o = (state_reg == RUN) && em_valid_reg && is_mem && misaligned;
  assign stall_o    = (state_reg == REQ) ? !dack_i : mem_go;

  always_comb begin
    be_mask   = 4'b1111;
    wdata_rep = em_sdata_reg;
    if (size_byte) begin
      be_mask   = 4'b0001 << a;
      wdata_rep = {4{em_sdata_reg[7:0]}};
    end else if (size_half) begin
      be_mask   = 4'b0011 << a;
      wdata_rep = {2{em_sdata_reg[15:0]}};
    end
  end

  always_comb begin
    dreq_o   = 1'b0;
    dwe_o    = 1'b0;
    daddr_o  = 32'd0;
    dbe_o    = 4'd0;
    dwdata_o = 32'd0;
    if (state_reg == REQ) begin
      dreq_o   = 1'b1;
      dwe_o    = is_store;
      daddr_o  = {em_result_reg[31:2], 2'b00};
      dbe_o    = be_mask;
      dwdata_o = wdata_rep;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign rbyte[gi] = drdata_i[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = rbyte[a];
  assign sel_half = a[1] ? drdata_i[31:16] : drdata_i[15:0];

  always_comb begin
    load_data = drdata_i;
    case (em_memop_reg)
      OP_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  load_data = {24'd0, sel_byte};
      OP_LH:   load_data = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  load_data = {16'd0, sel_half};
      default: load_data = drdata_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RUN;
      em_valid_reg  <= 1'b0;
      em_rd_reg     <= 5'd0;
      em_regwe_reg  <= 1'b0;
      em_result_reg <= 32'd0;
      em_memop_reg  <= 4'd0;
      em_sdata_reg  <= 32'd0;
      wb_rd_reg     <= 5'd0;
      wb_regwe_reg  <= 1'b0;
      wb_wbdata_reg <= 32'd0;
    end else begin
      if (!stall_o) begin
        em_valid_reg  <= valid_i;
        em_rd_reg     <= rd_i;
        em_regwe_reg  <= regwe_i;
        em_result_reg <= result_i;
        em_memop_reg  <= memop_i;
        em_sdata_reg  <= sdata_i;
      end
      case (state_reg)
        RUN: begin
          if (mem_go) begin
            state_reg <= REQ;
          end else begin
            wb_rd_reg     <= em_rd_reg;
            wb_regwe_reg  <= em_valid_reg && em_regwe_reg && !(is_mem && misaligned);
            wb_wbdata_reg <= em_result_reg;
          end
        end
        REQ: begin
          if (dack_i) begin
            state_reg     <= RUN;
            wb_rd_reg     <= em_rd_reg;
            wb_regwe_reg  <= is_load && em_regwe_reg;
            wb_wbdata_reg <= is_load ? load_data : em_result_reg;
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  // Loads are not forwarded from EX/MEM; their data only exists after the bus returns.
  assign ex_mem_rd     = em_rd_reg;
  assign ex_mem_regwe  = em_valid_reg && em_regwe_reg && !is_load;
  assign ex_mem_wbdata = em_result_reg;

  assign wb_rd     = wb_rd_reg;
  assign wb_regwe  = wb_regwe_reg;
  assign wb_wbdata = wb_wbdata_reg;

endmodule

// File: tb/tb_mem.sv
// Bench for the memory-access stage: directed plan cases plus random
// instruction streams checked against a transaction-level model.
module tb_mem;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [4:0]  rd_i;
  logic        regwe_i;
  logic [31:0] result_i;
  logic [3:0]  memop_i;
  logic [31:0] sdata_i;
  logic        stall_o, dreq_o, dwe_o;
  logic [31:0] daddr_o;
  logic [3:0]  dbe_o;
  logic [31:0] dwdata_o;
  logic [31:0] drdata_i;
  logic        dack_i;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_regwe;
  logic [31:0] ex_mem_wbdata;
  logic [4:0]  wb_rd;
  logic        wb_regwe;
  logic [31:0] wb_wbdata;
  logic        misalign_o;

  always #5 clk = ~clk;

  mem dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .rd_i(rd_i), .regwe_i(regwe_i),
    .result_i(result_i), .memop_i(memop_i), .sdata_i(sdata_i),
    .stall_o(stall_o), .dreq_o(dreq_o), .dwe_o(dwe_o), .daddr_o(daddr_o),
    .dbe_o(dbe_o), .dwdata_o(dwdata_o), .drdata_i(drdata_i), .dack_i(dack_i),
    .ex_mem_rd(ex_mem_rd), .ex_mem_regwe(ex_mem_regwe), .ex_mem_wbdata(ex_mem_wbdata),
    .wb_rd(wb_rd), .wb_regwe(wb_regwe), .wb_wbdata(wb_wbdata), .misalign_o(misalign_o)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] res;
    logic [3:0]  op;
    logic [31:0] sd;
    int          k;
    logic [31:0] word;
    bit          lit;
    logic [31:0] lit_addr;
    logic [3:0]  lit_be;
    logic [31:0] lit_dw;
    logic        lit_we;
    logic [31:0] lit_wb;
  } instr_t;

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } wb_t;

  instr_t prog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int width_of(input logic [3:0] op);
    case (op)
      4'd1, 4'd4, 4'd6: return 1;
      4'd2, 4'd5, 4'd7: return 2;
      4'd3, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic bit is_load(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic bit is_store(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  function automatic bit misal(input instr_t t);
    int w;
    w = width_of(t.op);
    return (w > 0) && ((int'(t.res[1:0]) % w) != 0);
  endfunction

  function automatic bit goes_to_bus(input instr_t t);
    return t.v && (width_of(t.op) > 0) && !misal(t);
  endfunction

  function automatic wb_t model_wb(input instr_t t);
    wb_t    r;
    int     w;
    int     a;
    longint v;
    r.rd   = t.rd;
    r.data = t.res;
    r.we   = t.v & t.we;
    w = width_of(t.op);
    a = int'(t.res[1:0]);
    if (t.v && w > 0) begin
      if (misal(t) || is_store(t.op)) begin
        r.we = 1'b0;
      end else begin
        v = longint'(t.word) >> (8 * a);
        if (w < 4) begin
          v = v % (longint'(1) << (8 * w));
          if ((t.op == 4'd1 || t.op == 4'd2) && v >= (longint'(1) << (8 * w - 1)))
            v = v - (longint'(1) << (8 * w));
        end
        r.data = v[31:0];
        r.we   = t.we;
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] model_be(input instr_t t);
    int w;
    int a;
    w = width_of(t.op);
    a = int'(t.res[1:0]);
    if (w == 4) return 4'hF;
    return 4'(((1 << w) - 1) << a);
  endfunction

  function automatic logic [31:0] model_dw(input instr_t t);
    case (width_of(t.op))
      1:       return 32'(t.sd[7:0]) * 32'h0101_0101;
      2:       return 32'(t.sd[15:0]) * 32'h0001_0001;
      default: return t.sd;
    endcase
  endfunction

  function automatic instr_t mk(input logic v, input logic [4:0] rd, input logic we,
                                input logic [31:0] res, input logic [3:0] op,
                                input logic [31:0] sd, input int k, input logic [31:0] word);
    instr_t t;
    t.v = v; t.rd = rd; t.we = we; t.res = res; t.op = op; t.sd = sd; t.k = k; t.word = word;
    t.lit = 1'b0; t.lit_addr = '0; t.lit_be = '0; t.lit_dw = '0; t.lit_we = 1'b0; t.lit_wb = '0;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    logic [3:0] op;
    op = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
    return mk(($urandom_range(0, 9) != 0), 5'($urandom), 1'($urandom), $urandom, op,
              $urandom, int'($urandom_range(0, 3)), $urandom);
  endfunction

  task automatic drive(input instr_t t);
    valid_i  = t.v;
    rd_i     = t.rd;
    regwe_i  = t.we;
    result_i = t.res;
    memop_i  = t.op;
    sdata_i  = t.sd;
  endtask

  task automatic check_wb(input string tag, input wb_t e);
    chk({tag, "_rd"}, 32'(wb_rd), 32'(e.rd));
    chk({tag, "_regwe"}, 32'(wb_regwe), 32'(e.we));
    chk({tag, "_wbdata"}, wb_wbdata, e.data);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall_o), 0);
    chk({tag, "_dreq"}, 32'(dreq_o), 0);
    chk({tag, "_bus"}, daddr_o | dwdata_o | {27'd0, dwe_o, dbe_o}, 0);
    chk({tag, "_exmem"}, ex_mem_wbdata | {26'd0, ex_mem_regwe, ex_mem_rd}, 0);
    chk({tag, "_wb"}, wb_wbdata | {26'd0, wb_regwe, wb_rd}, 0);
    chk({tag, "_misalign"}, 32'(misalign_o), 0);
  endtask

  task automatic run_prog();
    instr_t cur;
    wb_t    pexp;
    bit     have_prev;
    bit     plit;
    logic   plit_we;
    logic [31:0] plit_wb;
    int     n;
    have_prev = 1'b0;
    plit = 1'b0; plit_we = 1'b0; plit_wb = '0;
    pexp.rd = '0; pexp.we = 1'b0; pexp.data = '0;
    n = prog.size();
    if (n == 0) return;
    @(negedge clk);
    drive(prog[0]);
    @(posedge clk);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cur = prog[i];
      if (have_prev) check_wb("wb", pexp);
      if (plit) begin
        chk("lit_wb_regwe", 32'(wb_regwe), 32'(plit_we));
        chk("lit_wb_wbdata", wb_wbdata, plit_wb);
      end
      if (i + 1 < n) drive(prog[i + 1]);
      else drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
      // A stray ack while idle must have no effect.
      dack_i   = ($urandom_range(0, 3) == 0);
      drdata_i = $urandom;
      #1;
      chk("ex_mem_rd", 32'(ex_mem_rd), 32'(cur.rd));
      chk("ex_mem_wbdata", ex_mem_wbdata, cur.res);
      chk("ex_mem_regwe", 32'(ex_mem_regwe), 32'(cur.v & cur.we & !is_load(cur.op)));
      chk("misalign", 32'(misalign_o), 32'(cur.v && width_of(cur.op) > 0 && misal(cur)));
      chk("dreq_idle", 32'(dreq_o), 0);
      chk("bus_idle", daddr_o | dwdata_o | {27'd0, dwe_o, dbe_o}, 0);
      chk("stall_run", 32'(stall_o), 32'(goes_to_bus(cur)));
      if (goes_to_bus(cur)) begin
        @(posedge clk);
        #1 dack_i = 1'b0;
        for (int w = 0; w <= cur.k; w++) begin
          @(negedge clk);
          dack_i   = (w == cur.k);
          drdata_i = (w == cur.k) ? cur.word : $urandom;
          #1;
          chk("dreq", 32'(dreq_o), 1);
          chk("dwe", 32'(dwe_o), 32'(is_store(cur.op)));
          chk("daddr", daddr_o, cur.res - (cur.res % 4));
          chk("dbe", 32'(dbe_o), 32'(model_be(cur)));
          if (is_store(cur.op)) chk("dwdata", dwdata_o, model_dw(cur));
          chk("stall_req", 32'(stall_o), 32'(w != cur.k));
          chk("ex_mem_hold", ex_mem_wbdata, cur.res);
          if (have_prev) check_wb("wb_hold", pexp);
          if (cur.lit) begin
            chk("lit_daddr", daddr_o, cur.lit_addr);
            chk("lit_dbe", 32'(dbe_o), 32'(cur.lit_be));
            if (is_store(cur.op)) chk("lit_dwdata", dwdata_o, cur.lit_dw);
          end
          @(posedge clk);
        end
      end else begin
        @(posedge clk);
      end
      #1 dack_i = 1'b0;
      pexp = model_wb(cur);
      have_prev = 1'b1;
      plit = cur.lit; plit_we = cur.lit_we; plit_wb = cur.lit_wb;
      $display("txn %0d: v=%0d op=%0d res=%08h k=%0d -> rd=%0d we=%0d data=%08h",
               i, cur.v, cur.op, cur.res, cur.k, pexp.rd, pexp.we, pexp.data);
    end
    @(negedge clk);
    check_wb("wb", pexp);
    if (plit) begin
      chk("lit_wb_regwe", 32'(wb_regwe), 32'(plit_we));
      chk("lit_wb_wbdata", wb_wbdata, plit_wb);
    end
    prog.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    instr_t t;
    rst = 1'b1;
    dack_i = 1'b0;
    drdata_i = '0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check_all_zero("reset");
    rst = 1'b0;

    // Directed plan cases; literals pin the model.
    prog.push_back(mk(1, 5'd5, 1, 32'h1234, 4'd0, 0, 0, 0));
    prog.push_back(mk(1, 5'd6, 1, 32'h0055, 4'd0, 0, 0, 0));
    t = mk(1, 5'd7, 1, 32'h1003, 4'd1, 0, 2, 32'h80FF_FFFF);
    t.lit = 1; t.lit_addr = 32'h1000; t.lit_be = 4'b1000; t.lit_we = 1; t.lit_wb = 32'hFFFF_FF80;
    prog.push_back(t);
    t = mk(1, 5'd8, 1, 32'h2002, 4'd5, 0, 0, 32'hBEEF_1234);
    t.lit = 1; t.lit_addr = 32'h2000; t.lit_be = 4'b1100; t.lit_we = 1; t.lit_wb = 32'h0000_BEEF;
    prog.push_back(t);
    t = mk(1, 5'd9, 1, 32'h3002, 4'd7, 32'hAAAA_5678, 1, 0);
    t.lit = 1; t.lit_addr = 32'h3000; t.lit_be = 4'b1100; t.lit_dw = 32'h5678_5678;
    t.lit_we = 0; t.lit_wb = 32'h3002;
    prog.push_back(t);
    t = mk(1, 5'd10, 1, 32'h4001, 4'd3, 0, 0, 0);
    t.lit = 1; t.lit_we = 0; t.lit_wb = 32'h4001;
    prog.push_back(t);
    run_prog();

    // Reset while a request is outstanding, then a late ack.
    @(negedge clk);
    drive(mk(1, 5'd11, 1, 32'h5000, 4'd3, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    #1 chk("rstmid_stall", 32'(stall_o), 1);
    @(posedge clk);
    @(negedge clk);
    #1 chk("rstmid_dreq", 32'(dreq_o), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1 check_all_zero("rstmid");
    rst = 1'b0;
    dack_i = 1'b1;
    drdata_i = 32'hDEAD_BEEF;
    #1 chk("late_ack_stall", 32'(stall_o), 0);
    chk("late_ack_dreq", 32'(dreq_o), 0);
    @(posedge clk);
    #1 dack_i = 1'b0;
    @(negedge clk);
    #1 check_all_zero("late_ack");

    prog.push_back(mk(1, 5'd12, 1, 32'h0000_0777, 4'd0, 0, 0, 0));
    prog.push_back(mk(1, 5'd13, 1, 32'h0000_6004, 4'd8, 32'h1357_9BDF, 0, 0));
    run_prog();

    repeat (200) prog.push_back(rand_instr());
    run_prog();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
